// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: video-timing sequencer driving write enables, address and row pointer of a rotating line store.
module line_buffer_ctrl #(
  parameter int NUM_LINES = 5,
  parameter int X_W = 11,
  parameter int Y_W = 10,
  parameter int SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dv_i,
  input  logic                 hs_i,
  input  logic                 vs_i,
  output logic                 dv_o,
  output logic                 hs_o,
  output logic                 vs_o,
  output logic [NUM_LINES-1:0] wr_en,
  output logic [X_W-1:0]       wr_addr,
  output logic [SEL_W-1:0]     wr_sel,
  output logic [X_W-1:0]       x_index,
  output logic [Y_W-1:0]       y_index,
  output logic                 rows_ready,
  output logic [X_W:0]         line_width,
  output logic                 ovf
);
  localparam int FW = $clog2(NUM_LINES + 1);
  typedef enum logic [1:0] {S_WAIT_VS, S_BLANK, S_ACTIVE} state_t;
  state_t state_q, state_d;
  logic dv_q, dv_d, hs_q, hs_d, vs_q, vs_d;
  logic [NUM_LINES-1:0] wr_en_q, wr_en_d;
  logic [X_W-1:0] wr_addr_q, wr_addr_d, x_q, x_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [Y_W-1:0] y_q, y_d;
  logic rdy_q, rdy_d, ovf_q, ovf_d;
  logic [X_W:0] lw_q, lw_d, cnt_q, cnt_d, pix;
  logic [FW-1:0] fill_q, fill_d, fill_inc;
  logic vs_rise, take_px;
  always_comb begin
    vs_rise  = vs_i & ~vs_q;
    take_px  = (state_q != S_WAIT_VS) && dv_i && (state_q == S_ACTIVE || !dv_q);
    pix      = (state_q == S_ACTIVE) ? cnt_q : '0;
    fill_inc = (fill_q == FW'(NUM_LINES)) ? fill_q : fill_q + 1'b1;
    state_d  = state_q;
    dv_d     = dv_i;
    hs_d     = hs_i;
    vs_d     = vs_i;
    wr_en_d  = '0;
    x_d      = '0;
    cnt_d    = cnt_q;
    y_d      = y_q;
    sel_d    = sel_q;
    fill_d   = fill_q;
    rdy_d    = rdy_q;
    lw_d     = lw_q;
    ovf_d    = ovf_q;
    if (vs_rise) begin
      state_d = S_BLANK;
      cnt_d   = '0;
      y_d     = '0;
      sel_d   = '0;
      fill_d  = '0;
      rdy_d   = 1'b0;
      ovf_d   = 1'b0;
    end else if (take_px) begin
      // Pixels beyond the line store are counted for line_width but never written.
      state_d = S_ACTIVE;
      wr_en_d = pix[X_W] ? '0 : {{(NUM_LINES-1){1'b0}}, 1'b1} << sel_q;
      x_d     = pix[X_W] ? '1 : pix[X_W-1:0];
      ovf_d   = ovf_q | pix[X_W];
      cnt_d   = (&pix) ? pix : pix + 1'b1;
    end else if (state_q == S_ACTIVE) begin
      state_d = S_BLANK;
      cnt_d   = '0;
      lw_d    = cnt_q;
      y_d     = (&y_q) ? y_q : y_q + 1'b1;
      sel_d   = (sel_q == SEL_W'(NUM_LINES - 1)) ? '0 : sel_q + 1'b1;
      fill_d  = fill_inc;
      rdy_d   = rdy_q | (fill_inc >= FW'(NUM_LINES - 1));
    end
    wr_addr_d = x_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_WAIT_VS;
      dv_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      x_q       <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      sel_q     <= '0;
      fill_q    <= '0;
      rdy_q     <= 1'b0;
      lw_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dv_q      <= dv_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      x_q       <= x_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      sel_q     <= sel_d;
      fill_q    <= fill_d;
      rdy_q     <= rdy_d;
      lw_q      <= lw_d;
      ovf_q     <= ovf_d;
    end
  end
  assign dv_o       = dv_q;
  assign hs_o       = hs_q;
  assign vs_o       = vs_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_sel     = sel_q;
  assign x_index    = x_q;
  assign y_index    = y_q;
  assign rows_ready = rdy_q;
  assign line_width = lw_q;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: directed vector table plus randomized traffic against a line-counting reference model.
module tb_line_buffer_ctrl;
  localparam int NL = 5;
  localparam int XW = 4;
  localparam int YW = 10;
  localparam int SW = 3;
  logic clk = 0, rst = 1, dv_i = 0, hs_i = 0, vs_i = 0;
  logic dv_o, hs_o, vs_o, rows_ready, ovf;
  logic [NL-1:0] wr_en;
  logic [XW-1:0] wr_addr, x_index;
  logic [SW-1:0] wr_sel;
  logic [YW-1:0] y_index;
  logic [XW:0] line_width;
  int errors = 0, checks = 0;
  line_buffer_ctrl #(.NUM_LINES(NL), .X_W(XW), .Y_W(YW), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_sel(wr_sel), .x_index(x_index), .y_index(y_index),
    .rows_ready(rows_ready), .line_width(line_width), .ovf(ovf)
  );
  always #5 clk = ~clk;
  // Reference model: tracks whole lines completed this frame, derives pointers arithmetically.
  bit armed, in_line, m_ovf, p_dv, p_vs;
  int npix, nlines, m_lw, m_en, m_x;
  bit m_dv, m_hs, m_vs;
  task automatic model(input bit r, input bit d, input bit h, input bit v);
    if (r) begin
      armed = 0; in_line = 0; m_ovf = 0; npix = 0; nlines = 0; m_lw = 0;
      m_en = 0; m_x = 0; m_dv = 0; m_hs = 0; m_vs = 0; p_dv = 0; p_vs = 0;
      return;
    end
    m_dv = d; m_hs = h; m_vs = v; m_en = 0; m_x = 0;
    if (v && !p_vs) begin
      armed = 1; in_line = 0; npix = 0; nlines = 0; m_ovf = 0;
    end else if (armed && d && (in_line || !p_dv)) begin
      if (npix < (1 << XW)) begin
        m_en = 1 << (nlines % NL);
        m_x = npix;
      end else begin
        m_x = (1 << XW) - 1;
        m_ovf = 1;
      end
      npix++;
      in_line = 1;
    end else if (in_line) begin
      m_lw = npix > 31 ? 31 : npix;
      nlines++;
      in_line = 0;
      npix = 0;
    end
    p_dv = d; p_vs = v;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_model();
    chk("m_dv_o", int'(dv_o), int'(m_dv));
    chk("m_hs_o", int'(hs_o), int'(m_hs));
    chk("m_vs_o", int'(vs_o), int'(m_vs));
    chk("m_wr_en", int'(wr_en), m_en);
    chk("m_wr_addr", int'(wr_addr), m_x);
    chk("m_x_index", int'(x_index), m_x);
    chk("m_y_index", int'(y_index), nlines > 1023 ? 1023 : nlines);
    chk("m_wr_sel", int'(wr_sel), nlines % NL);
    chk("m_rows_ready", int'(rows_ready), int'(nlines >= NL - 1));
    chk("m_line_width", int'(line_width), m_lw);
    chk("m_ovf", int'(ovf), int'(m_ovf));
  endtask
  task automatic step(input bit r, input bit d, input bit h, input bit v);
    @(negedge clk);
    rst = r; dv_i = d; hs_i = h; vs_i = v;
    @(posedge clk);
    model(r, d, h, v);
    #1 chk_model();
  endtask
  typedef struct {
    int r, d, h, v, n, en, x, y, sel, rdy, lw, ov;
  } vec_t;
  vec_t tbl[22];
  int dv_left, gap_left, vs_left;
  bit rd, rh, rv, rr;
  initial begin
    tbl[0]  = '{1, 0, 0, 0, 2,  0,  0, 0, 0, 0,  0, 0};
    tbl[1]  = '{0, 1, 1, 0, 3,  0,  0, 0, 0, 0,  0, 0};
    tbl[2]  = '{0, 0, 0, 0, 2,  0,  0, 0, 0, 0,  0, 0};
    tbl[3]  = '{0, 0, 0, 1, 1,  0,  0, 0, 0, 0,  0, 0};
    tbl[4]  = '{0, 0, 0, 0, 2,  0,  0, 0, 0, 0,  0, 0};
    tbl[5]  = '{0, 1, 0, 0, 16, 1, 15, 0, 0, 0,  0, 0};
    tbl[6]  = '{0, 0, 1, 0, 1,  0,  0, 1, 1, 0, 16, 0};
    tbl[7]  = '{0, 0, 0, 0, 3,  0,  0, 1, 1, 0, 16, 0};
    tbl[8]  = '{0, 1, 0, 0, 1,  2,  0, 1, 1, 0, 16, 0};
    tbl[9]  = '{0, 0, 0, 0, 1,  0,  0, 2, 2, 0,  1, 0};
    tbl[10] = '{0, 1, 0, 0, 18, 0, 15, 2, 2, 0,  1, 1};
    tbl[11] = '{0, 0, 0, 0, 1,  0,  0, 3, 3, 0, 18, 1};
    tbl[12] = '{0, 1, 0, 0, 2,  8,  1, 3, 3, 0, 18, 1};
    tbl[13] = '{0, 0, 0, 0, 1,  0,  0, 4, 4, 1,  2, 1};
    tbl[14] = '{0, 1, 0, 0, 3, 16,  2, 4, 4, 1,  2, 1};
    tbl[15] = '{0, 1, 0, 1, 1,  0,  0, 0, 0, 0,  2, 0};
    tbl[16] = '{0, 1, 0, 0, 2,  0,  0, 0, 0, 0,  2, 0};
    tbl[17] = '{0, 0, 0, 0, 1,  0,  0, 0, 0, 0,  2, 0};
    tbl[18] = '{0, 1, 0, 0, 1,  1,  0, 0, 0, 0,  2, 0};
    tbl[19] = '{0, 1, 0, 0, 7,  1,  7, 0, 0, 0,  2, 0};
    tbl[20] = '{1, 1, 0, 0, 1,  0,  0, 0, 0, 0,  0, 0};
    tbl[21] = '{0, 0, 0, 0, 1,  0,  0, 0, 0, 0,  0, 0};
    for (int i = 0; i < 22; i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        step(tbl[i].r != 0, tbl[i].d != 0, tbl[i].h != 0, tbl[i].v != 0);
      chk($sformatf("v%0d_dv_o", i), int'(dv_o), tbl[i].r != 0 ? 0 : tbl[i].d);
      chk($sformatf("v%0d_hs_o", i), int'(hs_o), tbl[i].r != 0 ? 0 : tbl[i].h);
      chk($sformatf("v%0d_wr_en", i), int'(wr_en), tbl[i].en);
      chk($sformatf("v%0d_wr_addr", i), int'(wr_addr), tbl[i].x);
      chk($sformatf("v%0d_x_index", i), int'(x_index), tbl[i].x);
      chk($sformatf("v%0d_y_index", i), int'(y_index), tbl[i].y);
      chk($sformatf("v%0d_wr_sel", i), int'(wr_sel), tbl[i].sel);
      chk($sformatf("v%0d_rows_ready", i), int'(rows_ready), tbl[i].rdy);
      chk($sformatf("v%0d_line_width", i), int'(line_width), tbl[i].lw);
      chk($sformatf("v%0d_ovf", i), int'(ovf), tbl[i].ov);
    end
    // Ten clean 16-pixel lines: pointer wraps 4 -> 0 and y reaches 10.
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    for (int l = 0; l < 10; l++) begin
      for (int p = 0; p < 16; p++) begin
        step(0, 1, 0, 0);
        chk("seq_wr_en", int'(wr_en), 1 << (l % NL));
        chk("seq_addr", int'(wr_addr), p);
      end
      step(0, 0, 1, 0);
      chk("seq_sel", int'(wr_sel), (l + 1) % NL);
      chk("seq_rdy", int'(rows_ready), int'(l >= 3));
      step(0, 0, 0, 0);
    end
    chk("seq_y_end", int'(y_index), 10);
    dv_left = 0; gap_left = 3; vs_left = 0; rd = 0;
    for (int c = 0; c < 4000; c++) begin
      if (rd) begin
        if (dv_left > 0) dv_left--; else begin rd = 0; gap_left = $urandom_range(1, 6); end
      end else begin
        if (gap_left > 0) gap_left--; else begin rd = 1; dv_left = $urandom_range(0, 20); end
      end
      if (vs_left > 0) vs_left--; else if ($urandom_range(0, 249) == 0) vs_left = $urandom_range(1, 3);
      rv = vs_left > 0;
      rh = $urandom_range(0, 7) == 0;
      rr = $urandom_range(0, 1499) == 0;
      step(rr, rd, rh, rv);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
